// File: rtl/sb_pkt_xform_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkt_xform_pkg
// Shared types and helpers for the switchboard packet transformer.
//   xf_mode_e  : per-byte operation selector (PASS / ADD / XOR / SUB)
//   xform_byte : applies one operation to a single byte, modulo 256
// -----------------------------------------------------------------------------
package sb_pkt_xform_pkg;

    typedef enum logic [1:0] {
        XF_PASS = 2'd0,
        XF_ADD  = 2'd1,
        XF_XOR  = 2'd2,
        XF_SUB  = 2'd3
    } xf_mode_e;

    // Byte-local operation: 8-bit result width gives the mod-256 wrap and
    // guarantees no carry/borrow leaks into the neighbouring byte.
    function automatic logic [7:0] xform_byte(xf_mode_e m, logic [7:0] b, logic [7:0] op);
        logic [7:0] r;
        case (m)
            XF_ADD:  r = b + op;
            XF_XOR:  r = b ^ op;
            XF_SUB:  r = b - op;
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_pkt_fifo.sv
// -----------------------------------------------------------------------------
// sb_pkt_fifo
// Synchronous DEPTH-entry FIFO with registered storage; the head entry is
// presented on rdata whenever the FIFO is not empty.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push, wdata    : write request and data (ignored while full)
//   pop            : read request (ignored while empty)
//   rdata          : head entry
//   full, empty    : occupancy flags, derived from registered count
// -----------------------------------------------------------------------------
module sb_pkt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_q];

    // Power-of-two DEPTH lets the pointers wrap by plain overflow.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    // Storage is cleared on reset so the outputs read as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_ok) begin
                mem_q[wr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/sb_pkt_xform.sv
// -----------------------------------------------------------------------------
// sb_pkt_xform
// Per-byte packet transformer between two SB valid/ready endpoints.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mode, operand       : per-byte operation and its byte operand
//   in_data/dest/last   : input beat, qualified by in_valid / in_ready
//   out_data/dest/last  : transformed beat, qualified by out_valid / out_ready
//   pkt_count           : number of accepted last-beats (wraps)
//   done                : sticky flag, set when an all-ones beat is accepted
// -----------------------------------------------------------------------------
module sb_pkt_xform
    import sb_pkt_xform_pkg::*;
#(
    parameter int DW    = 256,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [7:0]    operand,
    input  logic [DW-1:0] in_data,
    input  logic [31:0]   in_dest,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic [31:0]   out_dest,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   pkt_count,
    output logic          done
);

    localparam int NB = DW / 8;
    localparam int W  = DW + 33;

    logic [DW-1:0] xf_data;
    logic [W-1:0]  head;
    logic          fifo_full, fifo_empty;
    logic          accept;
    logic [31:0]   pkt_count_q, pkt_count_d;
    logic          done_q, done_d;

    // mode/operand only matter on the accepting edge because the result is
    // captured into the buffer there.
    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign xf_data[i*8 +: 8] = xform_byte(xf_mode_e'(mode), in_data[i*8 +: 8], operand);
    end

    // Ready comes from the registered full flag only, so out_ready never
    // reaches in_ready combinationally; held low while reset is applied.
    assign in_ready  = !fifo_full && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;

    sb_pkt_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata ({in_last, in_dest, xf_data}),
        .pop   (out_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data = head[DW-1:0];
    assign out_dest = head[DW +: 32];
    assign out_last = head[W-1];

    always_comb begin
        pkt_count_d = pkt_count_q;
        done_d      = done_q;
        if (accept && in_last) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        if (accept && (&in_data)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            pkt_count_q <= pkt_count_d;
            done_q      <= done_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sb_pkt_xform.sv
module tb_sb_pkt_xform;

    localparam int DW    = 256;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    operand = 8'd0;
    logic [DW-1:0] in_data = '0;
    logic [31:0]   in_dest = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_dest;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   pkt_count;
    logic          done;

    sb_pkt_xform #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .operand   (operand),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: queue of expected {last, dest, data} beats plus counters.
    logic [DW+32:0] exp_q[$];
    logic [31:0]    m_count = '0;
    logic           m_done  = 1'b0;
    int             checks  = 0;
    int             errors  = 0;
    bit             last_acc;

    task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_xf(int m, int op, logic [DW-1:0] d);
        logic [DW-1:0] r;
        int b;
        for (int i = 0; i < DW / 8; i++) begin
            b = int'(d[i*8 +: 8]);
            case (m)
                1:       b = (b + op) % 256;
                2:       b = b ^ op;
                3:       b = (b - op + 256) % 256;
                default: b = b;
            endcase
            r[i*8 +: 8] = 8'(b);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    // One clock cycle: sample handshakes mid-cycle, update the model, then
    // check registered state just after the edge.
    task automatic step();
        bit acc, emi, rs;
        logic [DW+32:0] head;
        @(negedge clk);
        rs  = rst;
        acc = in_valid && in_ready;
        emi = out_valid && out_ready;
        last_acc = acc && !rs;
        if (!rs) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 512'(out_valid), 512'(0));
                end else begin
                    head = exp_q[0];
                    check("head_beat", 512'({out_last, out_dest, out_data}), 512'(head));
                    if (emi) void'(exp_q.pop_front());
                end
            end
            if (acc) begin
                exp_q.push_back({in_last, in_dest, model_xf(int'(mode), int'(operand), in_data)});
                if (in_last) m_count = m_count + 32'd1;
                if (in_data == {DW{1'b1}}) m_done = 1'b1;
            end
        end else begin
            exp_q.delete();
            m_count = '0;
            m_done  = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            check("pkt_count", 512'(pkt_count), 512'(m_count));
            check("done", 512'(done), 512'(m_done));
            check("out_valid", 512'(out_valid), 512'(exp_q.size() != 0));
            check("in_ready", 512'(in_ready), 512'(exp_q.size() < DEPTH));
        end
    endtask

    task automatic send(logic [DW-1:0] d, logic [31:0] dst, logic lst);
        bit got;
        in_data  = d;
        in_dest  = dst;
        in_last  = lst;
        in_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            got = last_acc;
        end
        if (!got) check("send_timeout", 512'(0), 512'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        check("drain_empty", 512'(exp_q.size()), 512'(0));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_beat", 512'({out_last, out_dest, out_data}), 512'(0));
        check("rst_pkt_count", 512'(pkt_count), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        rst = 1'b0;
        step();
        check("post_rst_ready", 512'(in_ready), 512'(1));
    endtask

    initial begin
        logic [DW-1:0] d;

        // Reset state.
        do_reset();

        // PASS with incrementing bytes.
        for (int i = 0; i < DW / 8; i++) d[i*8 +: 8] = 8'(i);
        mode = 2'd0; out_ready = 1'b1;
        send(d, 32'hCAFE_0001, 1'b1);
        check("pass_count", 512'(pkt_count), 512'(1));
        check("pass_data", 512'(out_data), 512'(d));
        drain();

        // ADD 1: per-byte wrap without carry.
        d = {DW{1'b1}};
        d[7:0] = 8'h7F;
        mode = 2'd1; operand = 8'h01; out_ready = 1'b0;
        send(d, 32'h0000_0042, 1'b0);
        d = '0;
        d[7:0] = 8'h80;
        check("add_wrap", 512'(out_data), 512'(d));
        check("add_done", 512'(done), 512'(0));
        drain();

        // Backpressure: third beat blocked until the buffer drains.
        out_ready = 1'b0; mode = 2'd2; operand = 8'h3C;
        send(rand_data(), 32'h100, 1'b0);
        send(rand_data(), 32'h101, 1'b0);
        in_data = rand_data(); in_dest = 32'h102; in_last = 1'b1; in_valid = 1'b1;
        step();
        check("bp_blocked", 512'(last_acc), 512'(0));
        step();
        check("bp_ready_low", 512'(in_ready), 512'(0));
        out_ready = 1'b1;
        send(in_data, in_dest, in_last);
        drain();

        // Mode change with data still buffered.
        out_ready = 1'b0;
        mode = 2'd2; operand = 8'h55;
        send(rand_data(), 32'h200, 1'b0);
        mode = 2'd3; operand = 8'h01;
        send('0, 32'h201, 1'b1);
        mode = 2'd0; operand = 8'h00;
        step();
        drain();

        // Terminator beat under ADD 1, then reset mid-operation.
        mode = 2'd1; operand = 8'h01; out_ready = 1'b1;
        send({DW{1'b1}}, 32'hFFFF_0000, 1'b1);
        check("term_data", 512'(out_data), 512'(0));
        check("term_done", 512'(done), 512'(1));
        drain();
        step();
        step();
        out_ready = 1'b0;
        send(rand_data(), 32'h300, 1'b0);
        send(rand_data(), 32'h301, 1'b0);
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Counter wrap from 2^32-1.
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_q;
        m_count = 32'hFFFF_FFFF;
        step();
        send(rand_data(), 32'h400, 1'b1);
        check("wrap_count", 512'(pkt_count), 512'(0));
        drain();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            mode      = 2'($urandom_range(0, 3));
            operand   = 8'($urandom());
            in_data   = rand_data();
            in_dest   = $urandom();
            in_last   = 1'($urandom());
            in_valid  = 1'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
